// File: rtl/dcache_lane_sequencer_pkg.sv
// Shared types for the dual-lane Dcache sequencer: FSM state encoding,
// Dcache access width codes and the lane liveness helper.
package dcache_lane_sequencer_pkg;

  typedef enum logic [2:0] {
    StIdle  = 3'd0,
    StWait0 = 3'd1,
    StReq1  = 3'd2,
    StWait1 = 3'd3,
    StDone  = 3'd4
  } seq_state_e;

  localparam logic [1:0] DcWB = 2'b00;
  localparam logic [1:0] DcWH = 2'b01;
  localparam logic [1:0] DcWW = 2'b10;

  // A lane still needs the Dcache unless it is a store suppressed by a flush.
  function automatic logic lane_live(input logic en, input logic rd, input logic flush);
    return en && (rd || !flush);
  endfunction

endpackage

// File: rtl/dcache_lane_sequencer_req.sv
// dcache_req_mux: combinational lane select of Dcache request fields.
// sel_i = 0 picks lane 0, sel_i = 1 picks lane 1.
module dcache_req_mux
  import dcache_lane_sequencer_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned ADDR_WIDTH = 32
) (
  input  logic                  sel_i,
  input  logic                  rd_0_i,
  input  logic [1:0]            width_0_i,
  input  logic                  sign_0_i,
  input  logic [ADDR_WIDTH-1:0] addr_0_i,
  input  logic [DATA_WIDTH-1:0] wdata_0_i,
  input  logic                  rd_1_i,
  input  logic [1:0]            width_1_i,
  input  logic                  sign_1_i,
  input  logic [ADDR_WIDTH-1:0] addr_1_i,
  input  logic [DATA_WIDTH-1:0] wdata_1_i,
  output logic                  rd_o,
  output logic [1:0]            width_o,
  output logic                  sign_o,
  output logic [ADDR_WIDTH-1:0] addr_o,
  output logic [DATA_WIDTH-1:0] wdata_o
);

  // Field select for the lane currently owning the Dcache port.
  always_comb begin
    rd_o    = sel_i ? rd_1_i    : rd_0_i;
    width_o = sel_i ? width_1_i : width_0_i;
    sign_o  = sel_i ? sign_1_i  : sign_0_i;
    addr_o  = sel_i ? addr_1_i  : addr_0_i;
    wdata_o = sel_i ? wdata_1_i : wdata_0_i;
  end

endmodule

// File: rtl/dcache_lane_sequencer.sv
// dcache_lane_sequencer: serialises the two MEM-stage lanes onto one Dcache
// port, lane 0 first, stalling the pipe until every enabled lane completes.
// Optional macro DCACHE_SEQ_PERF_EN adds stall-cycle and dual-issue counters.
module dcache_lane_sequencer
  import dcache_lane_sequencer_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned ADDR_WIDTH = 32
`ifdef DCACHE_SEQ_PERF_EN
  ,
  parameter int unsigned CNT_WIDTH  = 32
`endif
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  Lane_En_0_i,
  input  logic                  Lane_En_1_i,
  input  logic                  Lane_Rd_0_i,
  input  logic                  Lane_Rd_1_i,
  input  logic [1:0]            Lane_Width_0_i,
  input  logic [1:0]            Lane_Width_1_i,
  input  logic                  Lane_Sign_0_i,
  input  logic                  Lane_Sign_1_i,
  input  logic [ADDR_WIDTH-1:0] Lane_Addr_0_i,
  input  logic [ADDR_WIDTH-1:0] Lane_Addr_1_i,
  input  logic [DATA_WIDTH-1:0] Lane_WData_0_i,
  input  logic [DATA_WIDTH-1:0] Lane_WData_1_i,
  input  logic                  Csr_Memflush_i,
  output logic                  Dc_Req_o,
  output logic                  Dc_Rd_o,
  output logic [1:0]            Dc_Width_o,
  output logic                  Dc_Sign_o,
  output logic [ADDR_WIDTH-1:0] Dc_Addr_o,
  output logic [DATA_WIDTH-1:0] Dc_WData_o,
  input  logic                  Dc_Ready_i,
  input  logic                  Dc_RValid_i,
  input  logic [DATA_WIDTH-1:0] Dc_RData_i,
  output logic                  Mem_Stall_o,
  output logic                  Mem_Done_o,
  output logic [DATA_WIDTH-1:0] Mem_LdData_0_o,
  output logic [DATA_WIDTH-1:0] Mem_LdData_1_o
`ifdef DCACHE_SEQ_PERF_EN
  ,
  output logic [CNT_WIDTH-1:0]  Perf_StallCnt_o,
  output logic [CNT_WIDTH-1:0]  Perf_DualCnt_o
`endif
);

  seq_state_e            state_q, state_d;
  logic [DATA_WIDTH-1:0] ld_data_0_q, ld_data_0_d;
  logic [DATA_WIDTH-1:0] ld_data_1_q, ld_data_1_d;
  logic                  live_0, live_1, any_en;
  logic                  dc_req, sel, issue;

  assign live_0 = lane_live(Lane_En_0_i, Lane_Rd_0_i, Csr_Memflush_i);
  assign live_1 = lane_live(Lane_En_1_i, Lane_Rd_1_i, Csr_Memflush_i);
  assign any_en = Lane_En_0_i || Lane_En_1_i;
  assign issue  = dc_req && Dc_Ready_i;

  // Next-state, request and load-capture decode.
  always_comb begin
    state_d     = state_q;
    dc_req      = 1'b0;
    sel         = 1'b0;
    ld_data_0_d = ld_data_0_q;
    ld_data_1_d = ld_data_1_q;
    unique case (state_q)
      StIdle: begin
        if (live_0) begin
          dc_req = 1'b1;
          if (Dc_Ready_i) state_d = StWait0;
        end else if (live_1) begin
          dc_req = 1'b1;
          sel    = 1'b1;
          if (Dc_Ready_i) state_d = StWait1;
        end else if (any_en) begin
          // Every enabled lane was a flushed store: nothing to issue.
          state_d = StDone;
        end
      end
      StWait0: begin
        if (Dc_RValid_i) begin
          if (Lane_Rd_0_i) ld_data_0_d = Dc_RData_i;
          state_d = Lane_En_1_i ? StReq1 : StDone;
        end
      end
      StReq1: begin
        sel = 1'b1;
        if (live_1) begin
          dc_req = 1'b1;
          if (Dc_Ready_i) state_d = StWait1;
        end else begin
          state_d = StDone;
        end
      end
      StWait1: begin
        sel = 1'b1;
        if (Dc_RValid_i) begin
          if (Lane_Rd_1_i) ld_data_1_d = Dc_RData_i;
          state_d = StDone;
        end
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // State and captured load data registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StIdle;
      ld_data_0_q <= '0;
      ld_data_1_q <= '0;
    end else begin
      state_q     <= state_d;
      ld_data_0_q <= ld_data_0_d;
      ld_data_1_q <= ld_data_1_d;
    end
  end

  dcache_req_mux #(
    .DATA_WIDTH (DATA_WIDTH),
    .ADDR_WIDTH (ADDR_WIDTH)
  ) u_req_mux (
    .sel_i     (sel),
    .rd_0_i    (Lane_Rd_0_i),
    .width_0_i (Lane_Width_0_i),
    .sign_0_i  (Lane_Sign_0_i),
    .addr_0_i  (Lane_Addr_0_i),
    .wdata_0_i (Lane_WData_0_i),
    .rd_1_i    (Lane_Rd_1_i),
    .width_1_i (Lane_Width_1_i),
    .sign_1_i  (Lane_Sign_1_i),
    .addr_1_i  (Lane_Addr_1_i),
    .wdata_1_i (Lane_WData_1_i),
    .rd_o      (Dc_Rd_o),
    .width_o   (Dc_Width_o),
    .sign_o    (Dc_Sign_o),
    .addr_o    (Dc_Addr_o),
    .wdata_o   (Dc_WData_o)
  );

  assign Dc_Req_o       = dc_req;
  assign Mem_Stall_o    = ((state_q == StIdle) && any_en) || (state_q == StWait0) ||
                          (state_q == StReq1) || (state_q == StWait1);
  assign Mem_Done_o     = (state_q == StDone);
  assign Mem_LdData_0_o = ld_data_0_q;
  assign Mem_LdData_1_o = ld_data_1_q;

`ifdef DCACHE_SEQ_PERF_EN
  localparam logic [CNT_WIDTH-1:0] CntOne = CNT_WIDTH'(1);

  logic [CNT_WIDTH-1:0] stall_cnt_q, dual_cnt_q;

  // Free-running wrap-around perf counters; lane-1 issue from StReq1 implies lane 0 issued.
  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cnt_q <= '0;
      dual_cnt_q  <= '0;
    end else begin
      if (Mem_Stall_o) stall_cnt_q <= stall_cnt_q + CntOne;
      if ((state_q == StReq1) && issue) dual_cnt_q <= dual_cnt_q + CntOne;
    end
  end

  assign Perf_StallCnt_o = stall_cnt_q;
  assign Perf_DualCnt_o  = dual_cnt_q;
`else
  logic unused_issue;
  assign unused_issue = issue;
`endif

endmodule

// File: tb/tb_dcache_lane_sequencer.sv
// Scoreboard bench for dcache_lane_sequencer: stimulus pushes expected Dcache
// issues and bundle completions; a monitor pops and compares them.
module tb_dcache_lane_sequencer;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        en0, en1, rd0, rd1, sg0, sg1, flush, ready, rvalid;
  logic [1:0]  w0, w1;
  logic [31:0] a0, a1, wd0, wd1, rdata;
  logic        dc_req, dc_rd, dc_sign, stall, done;
  logic [1:0]  dc_width;
  logic [31:0] dc_addr, dc_wdata, ld0, ld1;
`ifdef DCACHE_SEQ_PERF_EN
  logic [31:0] perf_stall, perf_dual;
`endif

  always #5 clk = ~clk;

  dcache_lane_sequencer dut (
    .clk            (clk),
    .rst            (rst),
    .Lane_En_0_i    (en0),
    .Lane_En_1_i    (en1),
    .Lane_Rd_0_i    (rd0),
    .Lane_Rd_1_i    (rd1),
    .Lane_Width_0_i (w0),
    .Lane_Width_1_i (w1),
    .Lane_Sign_0_i  (sg0),
    .Lane_Sign_1_i  (sg1),
    .Lane_Addr_0_i  (a0),
    .Lane_Addr_1_i  (a1),
    .Lane_WData_0_i (wd0),
    .Lane_WData_1_i (wd1),
    .Csr_Memflush_i (flush),
    .Dc_Req_o       (dc_req),
    .Dc_Rd_o        (dc_rd),
    .Dc_Width_o     (dc_width),
    .Dc_Sign_o      (dc_sign),
    .Dc_Addr_o      (dc_addr),
    .Dc_WData_o     (dc_wdata),
    .Dc_Ready_i     (ready),
    .Dc_RValid_i    (rvalid),
    .Dc_RData_i     (rdata),
    .Mem_Stall_o    (stall),
    .Mem_Done_o     (done),
    .Mem_LdData_0_o (ld0),
    .Mem_LdData_1_o (ld1)
`ifdef DCACHE_SEQ_PERF_EN
    ,
    .Perf_StallCnt_o (perf_stall),
    .Perf_DualCnt_o  (perf_dual)
`endif
  );

  typedef struct {
    logic        rd;
    logic [1:0]  w;
    logic        sg;
    logic [31:0] a;
    logic [31:0] wd;
  } req_t;

  typedef struct {
    logic [31:0] ld0;
    logic [31:0] ld1;
    int          lat;
  } done_t;

  req_t        req_q[$];
  done_t       done_q[$];
  logic [31:0] mem [logic [31:0]];
  int          checks = 0, errors = 0, cyc = 0, start_cyc = 0, issue_cnt = 0, rv_delay = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Dcache model: one outstanding request, completes rv_delay cycles after issue.
  initial begin : responder
    logic        pend, fire, p_rd;
    logic [31:0] p_a, p_wd;
    int          cnt;
    pend = 1'b0; rvalid = 1'b0; rdata = '0; cnt = 0; p_rd = 1'b0; p_a = '0; p_wd = '0;
    forever begin
      @(negedge clk);
      fire = 1'b0;
      if (rst) begin
        pend = 1'b0;
      end else begin
        if (dc_req && ready) begin
          pend = 1'b1; cnt = rv_delay; p_rd = dc_rd; p_a = dc_addr; p_wd = dc_wdata;
          issue_cnt++;
        end
        if (pend) begin
          if (cnt == 0) begin fire = 1'b1; pend = 1'b0; end
          else cnt--;
        end
      end
      @(posedge clk);
      #1;
      rvalid = fire;
      rdata  = '0;
      if (fire) begin
        if (p_rd) rdata = mem.exists(p_a) ? mem[p_a] : 32'h0;
        else mem[p_a] = p_wd;
      end
    end
  end

  // Monitor: compare each issued request and each bundle completion.
  initial begin : monitor
    req_t  e;
    done_t d;
    forever begin
      @(negedge clk);
      if (!rst && dc_req && ready) begin
        if (req_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL issue_unexpected: got addr 0x%0h expected no issue", dc_addr);
        end else begin
          e = req_q.pop_front();
          check("issue_rd", dc_rd, e.rd);
          check("issue_width", dc_width, e.w);
          check("issue_sign", dc_sign, e.sg);
          check("issue_addr", dc_addr, e.a);
          check("issue_wdata", dc_wdata, e.wd);
        end
      end
      if (done) begin
        if (done_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL done_unexpected: got Mem_Done=1 expected 0");
        end else begin
          d = done_q.pop_front();
          check("done_ld0", ld0, d.ld0);
          check("done_ld1", ld1, d.ld1);
          check("done_latency", cyc - start_cyc, d.lat);
        end
      end
    end
  end

  // Runs one already-driven bundle to Mem_Done, then drops the lanes.
  task automatic run_bundle(input int ready_low, input int flush_at, input int exp_stall,
                            input int exp_issues, input string tag);
    int stall_seen = 0;
    int i = 0;
    int issues0 = issue_cnt;
    bit seen_done = 0;
    start_cyc = cyc;
    ready = (ready_low == 0);
    while (!seen_done && i < 60) begin
      @(negedge clk);
      if (stall) stall_seen++;
      if (ready_low > 0 && i <= ready_low) begin
        check({tag, "_hold_req"}, dc_req, 1'b1);
        check({tag, "_hold_addr"}, dc_addr, a0);
      end
      if (done) seen_done = 1;
      @(posedge clk);
      #1;
      if (i == ready_low - 1) ready = 1'b1;
      if (i == flush_at) flush = 1'b1;
      i++;
    end
    if (!seen_done) begin
      checks++; errors++;
      $display("FAIL %s_timeout: got no Mem_Done expected Mem_Done within 60 cycles", tag);
    end
    check({tag, "_stall_cycles"}, stall_seen, exp_stall);
    check({tag, "_issues"}, issue_cnt - issues0, exp_issues);
    en0 = 1'b0; en1 = 1'b0; flush = 1'b0; ready = 1'b1;
  endtask

  initial begin : watchdog
    #400000;
    $display("FAIL watchdog: got no finish expected finish before time limit");
    $fatal(1, "watchdog");
  end

  initial begin : stim
    en0 = 0; en1 = 0; rd0 = 0; rd1 = 0; sg0 = 0; sg1 = 0; flush = 0; ready = 1;
    w0 = 2'b00; w1 = 2'b00; a0 = '0; a1 = '0; wd0 = '0; wd1 = '0;
    mem[32'h100] = 32'hDEADBEEF;
    mem[32'h300] = 32'h0000_1234;
    mem[32'h400] = 32'h0000_005A;
    mem[32'h600] = 32'hCAFEF00D;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    // Reset state
    @(negedge clk);
    check("rst_req", dc_req, 1'b0);
    check("rst_stall", stall, 1'b0);
    check("rst_done", done, 1'b0);
    check("rst_ld0", ld0, 32'h0);
    check("rst_ld1", ld1, 32'h0);

    // Lane 0 LW 0x100, minimum latency
    req_q.push_back('{1'b1, 2'b10, 1'b0, 32'h100, 32'h0});
    done_q.push_back('{32'hDEADBEEF, 32'h0, 2});
    @(posedge clk); #1;
    en0 = 1; rd0 = 1; w0 = 2'b10; sg0 = 0; a0 = 32'h100; wd0 = 32'h0;
    run_bundle(0, -1, 2, 1, "lw_single");

    // Lane 0 SW then lane 1 LW to the same address: load must see the store
    req_q.push_back('{1'b0, 2'b10, 1'b0, 32'h200, 32'h11});
    req_q.push_back('{1'b1, 2'b10, 1'b0, 32'h200, 32'hAAAA});
    done_q.push_back('{32'hDEADBEEF, 32'h11, 4});
    @(posedge clk); #1;
    en0 = 1; rd0 = 0; w0 = 2'b10; a0 = 32'h200; wd0 = 32'h11;
    en1 = 1; rd1 = 1; w1 = 2'b10; a1 = 32'h200; wd1 = 32'hAAAA;
    run_bundle(0, -1, 4, 2, "st_ld_order");

    // Lane 0 LH with Dc_Ready low for 3 cycles
    req_q.push_back('{1'b1, 2'b01, 1'b1, 32'h300, 32'h0});
    done_q.push_back('{32'h1234, 32'h11, 5});
    @(posedge clk); #1;
    en0 = 1; rd0 = 1; w0 = 2'b01; sg0 = 1; a0 = 32'h300; wd0 = 32'h0;
    run_bundle(3, -1, 5, 1, "ready_hold");

    // Lane 0 LB + lane 1 SB, flush raised during WAIT0
    req_q.push_back('{1'b1, 2'b00, 1'b0, 32'h400, 32'h0});
    done_q.push_back('{32'h5A, 32'h11, 3});
    @(posedge clk); #1;
    en0 = 1; rd0 = 1; w0 = 2'b00; sg0 = 0; a0 = 32'h400; wd0 = 32'h0;
    en1 = 1; rd1 = 0; w1 = 2'b00; sg1 = 0; a1 = 32'h404; wd1 = 32'h77;
    run_bundle(0, 0, 3, 1, "flush_wait0");
    check("flush_store_absent", mem.exists(32'h404), 1'b0);

    // Dual load
    req_q.push_back('{1'b1, 2'b10, 1'b0, 32'h100, 32'h0});
    req_q.push_back('{1'b1, 2'b10, 1'b0, 32'h600, 32'h0});
    done_q.push_back('{32'hDEADBEEF, 32'hCAFEF00D, 4});
    @(posedge clk); #1;
    en0 = 1; rd0 = 1; w0 = 2'b10; a0 = 32'h100; wd0 = 32'h0;
    en1 = 1; rd1 = 1; w1 = 2'b10; a1 = 32'h600; wd1 = 32'h0;
    run_bundle(0, -1, 4, 2, "dual_load");

    // Reset while lane 1 is outstanding in WAIT1
    rv_delay = 3;
    req_q.push_back('{1'b1, 2'b10, 1'b0, 32'h500, 32'h0});
    @(posedge clk); #1;
    en0 = 0; en1 = 1; rd1 = 1; w1 = 2'b10; a1 = 32'h500; wd1 = 32'h0;
    @(negedge clk);
    @(posedge clk); #1;
    @(negedge clk);
    check("wait1_stall", stall, 1'b1);
    check("wait1_req", dc_req, 1'b0);
    @(posedge clk); #1;
    rst = 1'b1; en1 = 1'b0;
    @(posedge clk); #1;
    @(negedge clk);
    check("midrst_stall", stall, 1'b0);
    check("midrst_done", done, 1'b0);
    check("midrst_ld0", ld0, 32'h0);
    check("midrst_ld1", ld1, 32'h0);
`ifdef DCACHE_SEQ_PERF_EN
    check("midrst_perf_dual", perf_dual, 32'h0);
`endif
    @(posedge clk); #1;
    rst = 1'b0; rv_delay = 0;

`ifdef DCACHE_SEQ_PERF_EN
    for (int b = 0; b < 2; b++) begin
      req_q.push_back('{1'b1, 2'b10, 1'b0, 32'h100, 32'h0});
      req_q.push_back('{1'b1, 2'b10, 1'b0, 32'h600, 32'h0});
      done_q.push_back('{32'hDEADBEEF, 32'hCAFEF00D, 4});
      @(posedge clk); #1;
      en0 = 1; rd0 = 1; w0 = 2'b10; a0 = 32'h100;
      en1 = 1; rd1 = 1; w1 = 2'b10; a1 = 32'h600;
      run_bundle(0, -1, 4, 2, "perf_dual");
    end
    @(negedge clk);
    check("perf_dual_cnt", perf_dual, 32'd2);
    check("perf_stall_cnt", perf_stall, 32'd8);
`endif

    // Lane 1 store only: LdData registers keep their values
    req_q.push_back('{1'b0, 2'b10, 1'b0, 32'h700, 32'h99});
`ifdef DCACHE_SEQ_PERF_EN
    done_q.push_back('{32'hDEADBEEF, 32'hCAFEF00D, 2});
`else
    done_q.push_back('{32'h0, 32'h0, 2});
`endif
    @(posedge clk); #1;
    en0 = 0; en1 = 1; rd1 = 0; w1 = 2'b10; a1 = 32'h700; wd1 = 32'h99;
    run_bundle(0, -1, 2, 1, "st_lane1");
    check("st_lane1_mem", mem.exists(32'h700) ? mem[32'h700] : 32'h0, 32'h99);

    repeat (3) @(negedge clk);
    check("req_queue_empty", req_q.size(), 0);
    check("done_queue_empty", done_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
